// File: rtl/mor1kx_wb_sched_cappuccino_pkg.sv
// mor1kx_wb_sched_cappuccino_pkg: writeback source codes shared by the scheduler and its tag queue
package mor1kx_wb_sched_cappuccino_pkg;
   localparam int         OR1K_WB_SRC_W     = 2;
   localparam logic [1:0] OR1K_WB_SRC_ALU   = 2'd0;
   localparam logic [1:0] OR1K_WB_SRC_MUL   = 2'd1;
   localparam logic [1:0] OR1K_WB_SRC_LSU   = 2'd2;
   localparam logic [1:0] OR1K_WB_SRC_MFSPR = 2'd3;
endpackage

// File: rtl/mor1kx_wb_sched_cappuccino_wb_queue.sv
// mor1kx_wb_queue: in-order tag FIFO of {source unit, dest reg} with per-entry valid for the pending scoreboard
module mor1kx_wb_queue
   import mor1kx_wb_sched_cappuccino_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clr,
   input  logic [OR1K_WB_SRC_W-1:0] push_src,
   input  logic [AW-1:0]            push_adr,
   output logic [OR1K_WB_SRC_W-1:0] head_src,
   output logic [AW-1:0]            head_adr,
   output logic                     full,
   output logic                     empty,
   output logic [DEPTH-1:0]         ent_valid,
   output logic [DEPTH*AW-1:0]      ent_adr
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [OR1K_WB_SRC_W-1:0] src_q [DEPTH];
   logic [AW-1:0]            adr_q [DEPTH];
   logic [PW-1:0]            wr_ptr, rd_ptr;
   logic [CW-1:0]            cnt;

   assign head_src = src_q[rd_ptr];
   assign head_adr = adr_q[rd_ptr];
   assign full     = cnt == CW'(DEPTH);
   assign empty    = cnt == '0;

   // flatten entry addresses so the top can build the pending scoreboard
   always_comb begin
      ent_adr = '0;
      for (int i = 0; i < DEPTH; i++) ent_adr[i*AW +: AW] = adr_q[i];
   end

   // payload storage needs no reset; entries are only observed through valid/count
   always_ff @(posedge clk) begin
      if (push) begin
         src_q[wr_ptr] <= push_src;
         adr_q[wr_ptr] <= push_adr;
      end
   end

   // pointers, occupancy and valid vector; push and pop never hit the same slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst || clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         ent_valid <= '0;
      end else begin
         if (push) begin
            ent_valid[wr_ptr] <= 1'b1;
            wr_ptr            <= wr_ptr + PW'(1);
         end
         if (pop) begin
            ent_valid[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + PW'(1);
         end
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: rtl/mor1kx_wb_sched_cappuccino.sv
// mor1kx_wb_sched_cappuccino: in-order RF writeback scheduler driving the writeback mux selects and RF write port
module mor1kx_wb_sched_cappuccino
   import mor1kx_wb_sched_cappuccino_pkg::*;
#(
   parameter int OPTION_RF_ADDR_WIDTH  = 5,
   parameter int OPTION_WB_QUEUE_DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 issue_valid_i,
   output logic                                 issue_ready_o,
   input  logic                                 issue_rf_wb_i,
   input  logic [OR1K_WB_SRC_W-1:0]             issue_src_i,
   input  logic [OPTION_RF_ADDR_WIDTH-1:0]      issue_rfd_adr_i,
   input  logic [3:0]                           src_valid_i,
   output logic [3:0]                           src_ack_o,
   input  logic                                 flush_i,
   output logic                                 wb_op_mul_o,
   output logic                                 wb_op_lsu_load_o,
   output logic                                 wb_op_mfspr_o,
   output logic                                 rf_we_o,
   output logic [OPTION_RF_ADDR_WIDTH-1:0]      rf_waddr_o,
   output logic [2**OPTION_RF_ADDR_WIDTH-1:0]   rf_pending_o
);
   localparam int AW    = OPTION_RF_ADDR_WIDTH;
   localparam int DEPTH = OPTION_WB_QUEUE_DEPTH;

   logic [OR1K_WB_SRC_W-1:0] head_src;
   logic [AW-1:0]            head_adr;
   logic                     full, empty, push, consume;
   logic [DEPTH-1:0]         ent_valid;
   logic [DEPTH*AW-1:0]      ent_adr;

   assign issue_ready_o    = ~full & ~flush_i;
   assign push             = issue_valid_i & issue_ready_o & issue_rf_wb_i;
   assign consume          = ~empty & src_valid_i[head_src] & ~flush_i;
   assign src_ack_o        = consume ? 4'(1) << head_src : 4'd0;
   assign wb_op_mul_o      = ~empty & (head_src == OR1K_WB_SRC_MUL);
   assign wb_op_lsu_load_o = ~empty & (head_src == OR1K_WB_SRC_LSU);
   assign wb_op_mfspr_o    = ~empty & (head_src == OR1K_WB_SRC_MFSPR);

   mor1kx_wb_queue #(.DEPTH(DEPTH), .AW(AW)) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (consume),
      .clr       (flush_i),
      .push_src  (issue_src_i),
      .push_adr  (issue_rfd_adr_i),
      .head_src  (head_src),
      .head_adr  (head_adr),
      .full      (full),
      .empty     (empty),
      .ent_valid (ent_valid),
      .ent_adr   (ent_adr)
   );

   // pending scoreboard: every live entry marks its destination register
   always_comb begin
      rf_pending_o = '0;
      for (int i = 0; i < DEPTH; i++)
         if (ent_valid[i]) rf_pending_o[ent_adr[i*AW +: AW]] = 1'b1;
   end

   // the mux registers its result, so the RF write is issued one cycle after consume
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_o    <= 1'b0;
         rf_waddr_o <= '0;
      end else begin
         rf_we_o <= consume;
         if (consume) rf_waddr_o <= head_adr;
      end
   end
endmodule

// File: tb/tb_mor1kx_wb_sched_cappuccino.sv
// tb_mor1kx_wb_sched_cappuccino: scoreboard bench for the writeback scheduler
module tb_mor1kx_wb_sched_cappuccino;
   localparam int DEPTH = 4;
   localparam int AW    = 5;

   typedef struct packed { logic [1:0] src; logic [AW-1:0] adr; } ent_t;

   logic          clk = 1'b0, rst = 1'b1;
   logic          issue_valid = 1'b0, issue_rf_wb = 1'b0, flush = 1'b0;
   logic [1:0]    issue_src = '0;
   logic [AW-1:0] issue_adr = '0;
   logic [3:0]    src_valid = '0;
   logic          issue_ready_o, wb_op_mul_o, wb_op_lsu_load_o, wb_op_mfspr_o, rf_we_o;
   logic [3:0]    src_ack_o;
   logic [AW-1:0] rf_waddr_o;
   logic [31:0]   rf_pending_o;

   ent_t          mq[$];
   logic [AW-1:0] wbq[$];
   logic [AW-1:0] last_waddr = '0;
   int            checks = 0, failures = 0;

   always #5 clk = ~clk;

   mor1kx_wb_sched_cappuccino #(.OPTION_RF_ADDR_WIDTH(AW), .OPTION_WB_QUEUE_DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .issue_valid_i    (issue_valid),
      .issue_ready_o    (issue_ready_o),
      .issue_rf_wb_i    (issue_rf_wb),
      .issue_src_i      (issue_src),
      .issue_rfd_adr_i  (issue_adr),
      .src_valid_i      (src_valid),
      .src_ack_o        (src_ack_o),
      .flush_i          (flush),
      .wb_op_mul_o      (wb_op_mul_o),
      .wb_op_lsu_load_o (wb_op_lsu_load_o),
      .wb_op_mfspr_o    (wb_op_mfspr_o),
      .rf_we_o          (rf_we_o),
      .rf_waddr_o       (rf_waddr_o),
      .rf_pending_o     (rf_pending_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic issue(input logic v, input logic [1:0] s, input logic [AW-1:0] a, input logic wb);
      issue_valid = v;
      issue_src   = s;
      issue_adr   = a;
      issue_rf_wb = wb;
   endtask

   // check all outputs against the model mid-cycle, then advance the model past the edge
   task automatic cycle();
      logic [31:0] ep;
      bit          cons, push, ne;
      ent_t        h;
      @(negedge clk);
      ep = '0;
      foreach (mq[i]) ep[mq[i].adr] = 1'b1;
      ne   = mq.size() > 0;
      h    = ne ? mq[0] : '0;
      cons = ne && src_valid[h.src] && !flush;
      push = issue_valid && issue_rf_wb && mq.size() < DEPTH && !flush;
      chk("ready", 32'(issue_ready_o), 32'(mq.size() < DEPTH && !flush));
      chk("ack", 32'(src_ack_o), cons ? 32'(1) << h.src : 32'd0);
      chk("sel_mul", 32'(wb_op_mul_o), 32'(ne && h.src == 2'd1));
      chk("sel_lsu", 32'(wb_op_lsu_load_o), 32'(ne && h.src == 2'd2));
      chk("sel_spr", 32'(wb_op_mfspr_o), 32'(ne && h.src == 2'd3));
      chk("pending", rf_pending_o, ep);
      if (wbq.size() > 0) begin
         chk("rf_we", 32'(rf_we_o), 32'd1);
         last_waddr = wbq.pop_front();
      end else chk("rf_we", 32'(rf_we_o), 32'd0);
      chk("rf_waddr", 32'(rf_waddr_o), 32'(last_waddr));
      @(posedge clk);
      #1;
      if (flush) mq.delete();
      else begin
         if (cons) begin
            wbq.push_back(h.adr);
            src_valid[h.src] = 1'b0;
            void'(mq.pop_front());
         end
         if (push) mq.push_back({issue_src, issue_adr});
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      issue(1'b0, 2'd0, '0, 1'b0);
      src_valid = '0;
      flush = 1'b0;
      #1;
      chk("rst_we", 32'(rf_we_o), 32'd0);
      chk("rst_ready", 32'(issue_ready_o), 32'd1);
      chk("rst_pending", rf_pending_o, 32'd0);
      chk("rst_ack", 32'(src_ack_o), 32'd0);
      chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
      mq.delete();
      wbq.delete();
      last_waddr = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      cycle();
      // reset with three queued writes and one writeback in flight
      issue(1'b1, 2'd1, 5'd1, 1'b1); cycle();
      issue(1'b1, 2'd1, 5'd2, 1'b1); cycle();
      issue(1'b1, 2'd0, 5'd6, 1'b1); cycle();
      issue(1'b1, 2'd1, 5'd9, 1'b1); src_valid = 4'b0010; cycle();
      chk("pre_rst_we", 32'(rf_we_o), 32'd1);
      do_reset();
      cycle();
      // single ALU write to r3
      issue(1'b1, 2'd0, 5'd3, 1'b1); cycle();
      issue(1'b0, 2'd0, 5'd0, 1'b0);
      chk("t2_pend3", rf_pending_o[3], 32'd1);
      src_valid = 4'b0001; cycle();
      chk("t2_we", 32'(rf_we_o), 32'd1);
      chk("t2_waddr", 32'(rf_waddr_o), 32'd3);
      cycle();
      // LSU r4 ahead of ALU r5; ALU ready early must wait
      issue(1'b1, 2'd2, 5'd4, 1'b1); cycle();
      issue(1'b1, 2'd0, 5'd5, 1'b1); cycle();
      issue(1'b0, 2'd0, 5'd0, 1'b0);
      src_valid = 4'b0001;
      repeat (3) cycle();
      src_valid = 4'b0101;
      repeat (3) cycle();
      // fill with MUL ops, hold a fifth, consume while full
      src_valid = '0;
      for (int i = 0; i < 4; i++) begin issue(1'b1, 2'd1, AW'(8 + i), 1'b1); cycle(); end
      issue(1'b1, 2'd1, 5'd12, 1'b1);
      repeat (2) cycle();
      chk("t4_full", 32'(issue_ready_o), 32'd0);
      src_valid = 4'b0010; cycle();
      cycle();
      src_valid = 4'b0010; cycle();
      issue(1'b1, 2'd1, 5'd13, 1'b1); src_valid = 4'b0010; cycle();
      issue(1'b0, 2'd0, 5'd0, 1'b1);
      repeat (4) begin src_valid = 4'b0010; cycle(); end
      cycle();
      // two writes to r7 plus a non-writing op
      issue(1'b1, 2'd0, 5'd7, 1'b1); cycle();
      issue(1'b1, 2'd3, 5'd7, 1'b1); cycle();
      issue(1'b1, 2'd0, 5'd20, 1'b0); cycle();
      issue(1'b0, 2'd0, 5'd0, 1'b0);
      src_valid = 4'b0001; cycle();
      chk("t5_pend7_mid", rf_pending_o[7], 32'd1);
      src_valid = 4'b1000; cycle();
      chk("t5_pend7_end", rf_pending_o[7], 32'd0);
      cycle();
      // flush with SPR result valid; stale valid afterwards ignored
      issue(1'b1, 2'd3, 5'd9, 1'b1); cycle();
      issue(1'b1, 2'd3, 5'd10, 1'b1); cycle();
      issue(1'b0, 2'd0, 5'd0, 1'b0);
      src_valid = 4'b1000; flush = 1'b1; cycle();
      flush = 1'b0;
      chk("t6_we", 32'(rf_we_o), 32'd0);
      repeat (2) cycle();
      src_valid = '0;
      // random traffic
      for (int n = 0; n < 300; n++) begin
         issue($urandom_range(0, 1) == 1, 2'($urandom), AW'($urandom), $urandom_range(0, 3) != 0);
         src_valid = src_valid | 4'($urandom & $urandom);
         flush = $urandom_range(0, 29) == 0;
         cycle();
      end
      issue(1'b0, 2'd0, 5'd0, 1'b0);
      flush = 1'b0;
      repeat (2) cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
